// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA: reads up to BUF words into a staging
// buffer over the shared bus, writes them back out, then raises done_irq.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// REQ   | bus requested, waiting for the first grant
// READ  | one word read into the staging buffer per granted cycle
// WRITE | one word written from the staging buffer per granted cycle
// DONE  | done_irq held until the CPU acknowledges
module dma_ctrl #(
  parameter int SZ  = 8,
  parameter int WSZ = 8,
  parameter int BUF = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [SZ-1:0]  cmd_src,
  input  logic [SZ-1:0]  cmd_dst,
  input  logic [SZ-1:0]  cmd_len,
  output logic           bus_req,
  input  logic           bus_gnt,
  output logic [SZ-1:0]  mem_addr,
  output logic           mem_we,
  output logic [WSZ-1:0] mem_wdata,
  input  logic [WSZ-1:0] mem_rdata,
  output logic           done_irq,
  input  logic           irq_ack,
  output logic           busy,
  output logic           err
);

  localparam int IW = (BUF > 1) ? $clog2(BUF) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [SZ-1:0]  src_r;
  logic [SZ-1:0]  dst_r;
  logic [SZ-1:0]  len_r;
  logic [SZ-1:0]  idx;
  logic [SZ-1:0]  words_left;
  logic [WSZ-1:0] stage_mem [BUF];

  logic cmd_acc;
  logic len_bad;
  logic last_word;
  logic rd_xfer;
  logic wr_xfer;

  assign cmd_acc   = cmd_valid && (state == IDLE);
  assign len_bad   = (cmd_len == '0) || (cmd_len > SZ'(BUF));
  assign last_word = (words_left == SZ'(1));
  assign rd_xfer   = (state == READ) && bus_gnt;
  assign wr_xfer   = (state == WRITE) && bus_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = len_bad ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (bus_gnt && last_word) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (bus_gnt && last_word) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (irq_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    bus_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done_irq  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      REQ: begin
        bus_req = 1'b1;
      end
      READ: begin
        bus_req  = 1'b1;
        mem_addr = src_r + idx;
      end
      WRITE: begin
        bus_req   = 1'b1;
        mem_we    = bus_gnt;
        mem_addr  = dst_r + idx;
        mem_wdata = stage_mem[idx[IW-1:0]];
      end
      DONE: begin
        done_irq = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // words_left counts down to the terminal word; idx forms the address offset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_r      <= '0;
      dst_r      <= '0;
      len_r      <= '0;
      idx        <= '0;
      words_left <= '0;
      err        <= 1'b0;
    end else if (cmd_acc) begin
      src_r      <= cmd_src;
      dst_r      <= cmd_dst;
      len_r      <= cmd_len;
      idx        <= '0;
      words_left <= cmd_len;
      err        <= len_bad;
    end else if (rd_xfer) begin
      if (last_word) begin
        idx        <= '0;
        words_left <= len_r;
      end else begin
        idx        <= idx + SZ'(1);
        words_left <= words_left - SZ'(1);
      end
    end else if (wr_xfer) begin
      idx        <= idx + SZ'(1);
      words_left <= words_left - SZ'(1);
    end
  end

  // Staging buffer holds no reset; its contents are only read after being filled.
  always_ff @(posedge clk) begin
    if (rd_xfer) begin
      stage_mem[idx[IW-1:0]] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: stimulus pushes expected writes and completion
// times, a negedge monitor pops and compares whenever the DUT presents them.
module tb_dma_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_src;
  logic [7:0] cmd_dst;
  logic [7:0] cmd_len;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       done_irq;
  logic       irq_ack;
  logic       busy;
  logic       err;

  dma_ctrl #(.SZ(8), .WSZ(8), .BUF(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done_irq  (done_irq),
    .irq_ack   (irq_ack),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int cyc;
    int err;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_count = 0;
  int acc;

  logic [7:0] mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // initial memory image: mem[a] = 10*(a-4) mod 256, so mem[5..7] = 10,20,30
  function automatic int exp_mem(input int a);
    return (10 * (a - 4)) & 255;
  endfunction

  assign mem_rdata = mem[mem_addr];

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(exp_mem(a));
    forever begin
      @(posedge clk);
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_count++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  logic  done_prev = 1'b0;
  wr_t   we_exp;
  done_t dn_exp;
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        we_exp = wr_q.pop_front();
        chk("wr_addr", int'(mem_addr), we_exp.addr);
        chk("wr_data", int'(mem_wdata), we_exp.data);
      end
    end
    if (!bus_gnt) chk("we_gated", int'(mem_we), 0);
    if (done_irq && !done_prev) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        dn_exp = done_q.pop_front();
        chk("done_cycle", cyc, dn_exp.cyc);
        chk("done_err", int'(err), dn_exp.err);
      end
    end
    done_prev = done_irq;
  end

  // all drive tasks start and end 1 time unit after a rising edge
  task automatic issue(input int src, input int dst, input int len);
    cmd_src   = 8'(src);
    cmd_dst   = 8'(dst);
    cmd_len   = 8'(len);
    cmd_valid = 1'b1;
    chk("cmd_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_irq && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", int'(done_irq), 1);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    irq_ack = 1'b0;
    chk("idle_after_ack", int'(busy), 0);
  endtask

  task automatic push_wr(input int addr, input int data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
  endtask

  task automatic push_done(input int at, input int e);
    done_t d;
    d.cyc = at;
    d.err = e;
    done_q.push_back(d);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"},   int'(bus_req),   0);
    chk({tag, "_mem_we"},    int'(mem_we),    0);
    chk({tag, "_done_irq"},  int'(done_irq),  0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_err"},       int'(err),       0);
    chk({tag, "_mem_addr"},  int'(mem_addr),  0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
  endtask

  logic [10:0] stall_pat;
  int          w0;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    bus_gnt   = 1'b1;
    irq_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // nominal transfer
    push_wr(12, 10); push_wr(13, 20); push_wr(14, 30);
    issue(5, 12, 3);
    push_done(acc + 7, 0);
    chk("nominal_err", int'(err), 0);
    wait_done();
    ack();

    // grant stalls: 2 cycles low in READ, 2 in WRITE
    stall_pat = 11'b11001110011;
    push_wr(12, 10); push_wr(13, 20); push_wr(14, 30);
    issue(5, 12, 3);
    push_done(acc + 11, 0);
    for (int k = 0; k < 11; k++) begin
      bus_gnt = stall_pat[k];
      @(posedge clk);
      #1;
    end
    bus_gnt = 1'b1;
    wait_done();
    ack();

    // rejected lengths go straight to DONE
    issue(5, 12, 0);
    push_done(acc, 1);
    chk("len0_bus_req", int'(bus_req), 0);
    chk("len0_err", int'(err), 1);
    wait_done();
    ack();
    chk("err_held", int'(err), 1);
    issue(5, 12, 5);
    push_done(acc, 1);
    chk("len5_bus_req", int'(bus_req), 0);
    chk("len5_done", int'(done_irq), 1);
    wait_done();
    ack();
    push_wr(12, 10); push_wr(13, 20); push_wr(14, 30);
    issue(5, 12, 3);
    push_done(acc + 7, 0);
    chk("err_cleared", int'(err), 0);
    wait_done();
    ack();

    // address wrap
    push_wr(1, exp_mem(254)); push_wr(2, exp_mem(255)); push_wr(3, exp_mem(0));
    issue(254, 1, 3);
    push_done(acc + 7, 0);
    wait_done();
    ack();

    // irq_ack and cmd_valid together in DONE
    push_wr(20, 10);
    issue(5, 20, 1);
    push_done(acc + 3, 0);
    wait_done();
    push_wr(21, 20);
    cmd_src   = 8'd6;
    cmd_dst   = 8'd21;
    cmd_len   = 8'd1;
    cmd_valid = 1'b1;
    irq_ack   = 1'b1;
    @(posedge clk);
    #1;
    chk("sim_not_accepted", int'(busy), 0);
    chk("sim_ready", int'(cmd_ready), 1);
    irq_ack = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    chk("sim_accepted", int'(busy), 1);
    push_done(acc + 3, 0);
    wait_done();
    ack();

    // reset mid-WRITE, right after the first write lands
    w0 = wr_count;
    push_wr(12, 10);
    issue(5, 12, 3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    chk("one_write", wr_count - w0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(cmd_ready), 1);
    chk("idle_after_rst", int'(busy), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("wr_q_drained", wr_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter SZ, default 8, SHALL set the address and length width.
REQ-002 Parameter WSZ, default 8, SHALL set the data word width.
REQ-003 Parameter BUF, default 4, SHALL set the staging-buffer depth, which is also the maximum transfer length in words.
REQ-004 clk  in  1  SHALL be the clock; reset rst, asynchronous, active-low; clock clk.
REQ-005 rst  in  1  SHALL be the asynchronous active-low reset.
REQ-006 cmd_valid  in  1  SHALL be the CPU command strobe.
REQ-007 cmd_ready  out  1  SHALL be high when a command can be accepted.
REQ-008 cmd_src, cmd_dst, cmd_len  in  SZ each  SHALL be the source address, destination address and word count.
REQ-009 bus_req  out  1  SHALL request the shared memory bus.
REQ-010 bus_gnt  in  1  SHALL be the bus grant from the arbiter.
REQ-011 mem_addr  out  SZ  SHALL be the memory address.
REQ-012 mem_we  out  1  SHALL select a write when high and a read when low.
REQ-013 mem_wdata  out  WSZ  SHALL be the write data.
REQ-014 mem_rdata  in  WSZ  SHALL be the read data, valid in the same cycle as mem_addr.
REQ-015 done_irq  out  1  SHALL be the completion interrupt to the CPU.
REQ-016 irq_ack  in  1  SHALL be the interrupt acknowledge from the CPU.
REQ-017 busy  out  1  SHALL be high in every state except IDLE.
REQ-018 err  out  1  SHALL flag that the last command was rejected.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, READ, WRITE and DONE.
REQ-020 cmd_ready SHALL equal (state==IDLE); a command SHALL be accepted on a clock edge where cmd_valid and cmd_ready are both high.
REQ-021 On acceptance the block SHALL latch src, dst and len, clear err and the word counter, and go to REQ; if len==0 or len>BUF it SHALL instead go directly to DONE with err=1 and no bus activity.
REQ-022 bus_req SHALL be high in REQ, READ and WRITE, and low in all other states.
REQ-023 REQ SHALL go to READ on an edge where bus_gnt=1, and SHALL otherwise hold.
REQ-024 READ, on each edge with bus_gnt=1, SHALL do the following: mem_addr=src+i, mem_we=0, capture buf[i]=mem_rdata, and increment i.
REQ-025 After the len-th read, READ SHALL clear i and go to WRITE.
REQ-026 WRITE, on each edge with bus_gnt=1, SHALL do the following: mem_addr=dst+i, mem_we=1, mem_wdata=buf[i], and increment i.
REQ-027 After the len-th write, WRITE SHALL go to DONE.
REQ-028 mem_we SHALL be combinationally gated: high only when state==WRITE and bus_gnt=1.
REQ-029 When bus_gnt=0 in READ or WRITE, the block SHALL stall with counters and buffer unchanged and mem_we=0.
REQ-030 mem_addr SHALL drive src+i in READ, dst+i in WRITE, and 0 otherwise.
REQ-031 Address arithmetic SHALL wrap modulo 2^SZ; for example src=254 with len=3 SHALL read addresses 254, 255, 0.
REQ-032 DONE SHALL hold done_irq=1 until an edge with irq_ack=1, then go to IDLE.
REQ-033 irq_ack SHALL be ignored in every state other than DONE.
REQ-034 cmd_valid in DONE SHALL be ignored, including when it coincides with irq_ack; the command SHALL be accepted only once the block is in IDLE.
REQ-035 With bus_gnt held high, done_irq SHALL rise exactly 2*len+1 edges after the acceptance edge.

Reset
REQ-036 rst=0 SHALL force IDLE immediately, regardless of clk.
REQ-037 During reset, bus_req, mem_we, done_irq, busy and err SHALL all be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-038 Buffer contents after reset SHALL be don't-care.
REQ-039 A reset asserted mid-transfer SHALL abort the transfer with no further memory writes.

Verification
REQ-040 Nominal transfer: mem[5..7]=10,20,30; src=5, dst=12, len=3; gnt tied high -> three reads, then writes 12=10, 13=20, 14=30; done_irq rises 7 edges after acceptance; err=0.
REQ-041 Grant stall: same command with bus_gnt dropped for 2 cycles in READ and 2 in WRITE -> identical data written, mem_we never high while gnt=0, done_irq 4 edges later than in REQ-040.
REQ-042 Error: len=0 and, separately, len=5 with BUF=4 -> no bus_req, DONE on the next edge with err=1; the next valid command clears err.
REQ-043 Wrap: src=254, dst=1, len=3 -> reads 254, 255, 0, then writes 1, 2, 3.
REQ-044 Reset mid-WRITE after the first write -> all outputs 0 immediately; only one memory location modified; cmd_ready=1 after reset release.
REQ-045 Simultaneous events: irq_ack and cmd_valid in the same DONE cycle -> IDLE with the command not accepted; the command held one more cycle is accepted.
